vga_mode_ctrl: RTL and testbench

Frame-level controller for the video blanking/timing generator. It measures the pix_start frame period, decides when the measured geometry matches the selected video mode, and sequences mode changes (ds80 / screen_mode) so they are applied only on frame boundaries. While the timing is not proven stable, it holds the display blanked. It sits between the mode registers and the blank generator, driving that generator's mode inputs and an OR-in blank.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_period_meter.sv | 43 ++++
 rtl/vga_mode_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_mode_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared frame geometry, expected frame periods and controller state encoding
// for the video mode controller.
package vga_timing_pkg;

  localparam int unsigned H_TOTAL_SPECTRUM = 896;
  localparam int unsigned H_TOTAL_PROFI    = 768;
  localparam int unsigned V_TOTAL_640      = 640;
  localparam int unsigned V_TOTAL_624      = 624;

  localparam int unsigned PERIOD_PROFI_SC  = H_TOTAL_PROFI    * V_TOTAL_640;  // 491520
  localparam int unsigned PERIOD_PROFI_DC  = H_TOTAL_PROFI    * V_TOTAL_624;  // 479232
  localparam int unsigned PERIOD_CLASSIC   = H_TOTAL_SPECTRUM * V_TOTAL_624;  // 559104
  localparam int unsigned PERIOD_PENTAGON  = H_TOTAL_SPECTRUM * V_TOTAL_640;  // 573440

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_NOSYNC  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } vga_state_e;

  typedef struct packed {
    logic       ds80;
    logic [1:0] screen_mode;
  } vga_mode_t;

  // Profi 80-column mode takes precedence over the spectrum timing select.
  function automatic logic [CNT_W-1:0] mode_period(
    input vga_mode_t        m,
    input bit               single_clock,
    input logic [CNT_W-1:0] p_sc,
    input logic [CNT_W-1:0] p_dc,
    input logic [CNT_W-1:0] p_cl,
    input logic [CNT_W-1:0] p_pe
  );
    if (m.ds80)                    return single_clock ? p_sc : p_dc;
    else if (m.screen_mode == 2'b01) return p_cl;
    else                           return p_pe;
  endfunction

endpackage

// File: rtl/vga_period_meter.sv
// Frame-start edge detector plus saturating period counter and no-signal timeout.
module vga_period_meter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1048575
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_start,
  output logic             frame_edge,
  output logic [CNT_W-1:0] period,
  output logic             timeout,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CLKS);

  logic s1, s2;
  logic [CNT_W-1:0] cnt;

  // The strobe is registered so the FSM sees a clean one-cycle pulse; the
  // counter restarts on the same pulse, so a steady source of period P
  // reads back exactly P at the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      frame_edge <= 1'b0;
      cnt        <= '0;
    end else begin
      s1         <= pix_start;
      s2         <= s1;
      frame_edge <= s1 & ~s2;
      if (frame_edge)          cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
  end

  assign period    = cnt;
  assign timeout   = (cnt == TMO);
  assign saturated = (cnt == CNT_MAX);

endmodule

// File: rtl/vga_mode_ctrl.sv
// Frame-level mode controller: measures the frame period, locks onto the applied
// mode and applies requested ds80/screen_mode changes only on frame boundaries.
module vga_mode_ctrl
  import vga_timing_pkg::*;
#(
  parameter bit          SINGLE_CLOCK  = 1'b0,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned TOL           = 16,
  parameter int unsigned TIMEOUT_CLKS  = 1048575,
  // Expected periods default to the real geometry; small values allow
  // scaled-down frames for fast bring-up.
  parameter int unsigned P_PROFI_SC    = PERIOD_PROFI_SC,
  parameter int unsigned P_PROFI_DC    = PERIOD_PROFI_DC,
  parameter int unsigned P_CLASSIC     = PERIOD_CLASSIC,
  parameter int unsigned P_PENTAGON    = PERIOD_PENTAGON
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ds80_in,
  input  logic [1:0]       screen_mode_in,
  input  logic             pix_start,
  output logic             ds80_out,
  output logic [1:0]       screen_mode_out,
  output logic             mode_apply,
  output logic             force_blank,
  output logic             locked,
  output logic             no_signal,
  output logic [CNT_W-1:0] frame_len
);

  localparam logic [3:0]  SETTLE_V = 4'(SETTLE_FRAMES);
  localparam logic [20:0] TOL_V    = 21'(TOL);

  logic             frame_edge, timeout, saturated;
  logic [CNT_W-1:0] period;

  vga_period_meter #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_meter (
    .clk        (clk),
    .reset      (reset),
    .pix_start  (pix_start),
    .frame_edge (frame_edge),
    .period     (period),
    .timeout    (timeout),
    .saturated  (saturated)
  );

  vga_state_e       state, state_n;
  logic [3:0]       match_cnt, match_cnt_n, mc_inc;
  vga_mode_t        mode_q, mode_n, req;
  logic             apply_n;
  logic [CNT_W-1:0] frame_len_n;

  logic [CNT_W-1:0]  exp_len;
  logic signed [20:0] diff;
  logic [20:0]       adiff;
  logic              match, pending;

  assign req     = '{ds80: ds80_in, screen_mode: screen_mode_in};
  assign pending = (req != mode_q);
  assign mc_inc  = match_cnt + 4'd1;

  assign exp_len = mode_period(mode_q, SINGLE_CLOCK, CNT_W'(P_PROFI_SC), CNT_W'(P_PROFI_DC),
                               CNT_W'(P_CLASSIC), CNT_W'(P_PENTAGON));

  // A saturated counter never matches, whatever the tolerance.
  always_comb begin
    diff  = $signed({1'b0, period}) - $signed({1'b0, exp_len});
    adiff = diff[20] ? 21'(-diff) : 21'(diff);
    match = ~saturated && (adiff <= TOL_V);
  end

  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    mode_n      = mode_q;
    apply_n     = 1'b0;
    frame_len_n = frame_len;
    case (state)
      ST_NOSYNC: begin
        // Without a frame reference there is nothing to tear; apply at once.
        if (pending) begin
          mode_n  = req;
          apply_n = 1'b1;
        end
        if (frame_edge) begin
          state_n     = ST_MEASURE;
          match_cnt_n = '0;
        end
      end
      default: begin
        if (frame_edge) begin
          frame_len_n = period;
          if (pending) begin
            // The period that just ended belongs to the old mode: skip it.
            mode_n      = req;
            apply_n     = 1'b1;
            state_n     = ST_MEASURE;
            match_cnt_n = '0;
          end else if (!match) begin
            state_n     = ST_MEASURE;
            match_cnt_n = '0;
          end else if (state == ST_MEASURE) begin
            match_cnt_n = mc_inc;
            if (mc_inc >= SETTLE_V) state_n = ST_LOCKED;
          end
        end else if (timeout) begin
          state_n     = ST_NOSYNC;
          match_cnt_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_NOSYNC;
      match_cnt  <= '0;
      mode_q     <= '0;
      mode_apply <= 1'b0;
      frame_len  <= '0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_cnt_n;
      mode_q     <= mode_n;
      mode_apply <= apply_n;
      frame_len  <= frame_len_n;
    end
  end

  assign ds80_out        = mode_q.ds80;
  assign screen_mode_out = mode_q.screen_mode;
  assign locked          = (state == ST_LOCKED);
  assign force_blank     = ~locked;
  assign no_signal       = (state == ST_NOSYNC);

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Randomized and directed bench for vga_mode_ctrl against a frame-event reference model.
module tb_vga_mode_ctrl;

  localparam int SETTLE = 2;
  localparam int TOLV   = 16;
  localparam int TMO    = 1000;
  localparam int P_SC   = 360;
  localparam int P_DC   = 340;
  localparam int P_CL   = 380;
  localparam int P_PE   = 400;
  localparam int SAT    = 1048575;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds80_in = 1'b0;
  logic [1:0]  screen_mode_in = 2'b00;
  logic        pix_start = 1'b0;
  logic        ds80_out, mode_apply, force_blank, locked, no_signal;
  logic [1:0]  screen_mode_out;
  logic [19:0] frame_len;

  vga_mode_ctrl #(
    .SINGLE_CLOCK(1'b0), .SETTLE_FRAMES(SETTLE), .TOL(TOLV), .TIMEOUT_CLKS(TMO),
    .P_PROFI_SC(P_SC), .P_PROFI_DC(P_DC), .P_CLASSIC(P_CL), .P_PENTAGON(P_PE)
  ) dut (
    .clk(clk), .reset(reset), .ds80_in(ds80_in), .screen_mode_in(screen_mode_in),
    .pix_start(pix_start), .ds80_out(ds80_out), .screen_mode_out(screen_mode_out),
    .mode_apply(mode_apply), .force_blank(force_blank), .locked(locked),
    .no_signal(no_signal), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int apply_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks frame events, clocks since the last frame, the
  // applied mode and a run of good frames, rather than a state encoding.
  bit          m_h1, m_h2, m_ev;
  int          m_since;
  bit          m_sync, m_lock, m_apply, m_ds;
  logic [1:0]  m_sm;
  int          m_good, m_flen;

  function automatic int exp_period(input bit ds, input logic [1:0] sm);
    if (ds) return P_DC;
    return (sm == 2'b01) ? P_CL : P_PE;
  endfunction

  task automatic model_tick();
    bit pend, good, new_ev;
    int d;
    if (reset) begin
      m_h1 = 0; m_h2 = 0; m_ev = 0; m_since = 0;
      m_sync = 0; m_lock = 0; m_apply = 0; m_ds = 0; m_sm = 2'b00;
      m_good = 0; m_flen = 0;
      return;
    end
    pend = ({ds80_in, screen_mode_in} != {m_ds, m_sm});
    d    = m_since - exp_period(m_ds, m_sm);
    good = (m_since != SAT) && (d <= TOLV) && (d >= -TOLV);
    m_apply = 0;
    if (!m_sync) begin
      if (pend) begin m_ds = ds80_in; m_sm = screen_mode_in; m_apply = 1; end
      if (m_ev) begin m_sync = 1; m_good = 0; end
    end else if (m_ev) begin
      m_flen = m_since;
      if (pend) begin
        m_ds = ds80_in; m_sm = screen_mode_in; m_apply = 1; m_lock = 0; m_good = 0;
      end else if (good) begin
        if (!m_lock) begin
          m_good++;
          if (m_good >= SETTLE) m_lock = 1;
        end
      end else begin
        m_lock = 0; m_good = 0;
      end
    end else if (m_since == TMO) begin
      m_sync = 0; m_lock = 0; m_good = 0;
    end
    new_ev  = m_h1 && !m_h2;
    m_since = m_ev ? 1 : ((m_since == SAT) ? SAT : m_since + 1);
    m_h2    = m_h1;
    m_h1    = pix_start;
    m_ev    = new_ev;
  endtask

  task automatic step();
    logic [26:0] got, exp;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    got = {ds80_out, screen_mode_out, mode_apply, force_blank, locked, no_signal, frame_len};
    exp = {m_ds, m_sm, m_apply, !m_lock, m_lock, !m_sync, 20'(m_flen)};
    chk("outs", 32'(got), 32'(exp));
    if (mode_apply) apply_seen++;
  endtask

  // One frame of len clocks: pix_start rises at index 0; the controller acts
  // on it at index 2. Mode inputs optionally change at index chg_at.
  task automatic frame(input int len, input int chg_at, input bit nds, input logic [1:0] nsm);
    for (int i = 0; i < len; i++) begin
      pix_start = (i < 4);
      if (i == chg_at) begin ds80_in = nds; screen_mode_in = nsm; end
      step();
    end
    pix_start = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_start = 1'b0;
    repeat (n) step();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int k, base, len, chg, ap0;
    bit nds;
    logic [1:0] nsm;

    repeat (3) step();
    chk("reset_fb", force_blank, 1);
    chk("reset_nosig", no_signal, 1);
    chk("reset_flen", frame_len, 0);
    reset = 1'b0;

    // No edges: stays without signal well past the timeout.
    idle(5000);
    chk("noedge_nosig", no_signal, 1);
    chk("noedge_fb", force_blank, 1);

    // Pentagon stable.
    repeat (4) frame(P_PE, -1, 0, 2'b00);
    chk("pent_locked", locked, 1);
    chk("pent_fb", force_blank, 0);
    chk("pent_flen", frame_len, P_PE);

    // Mode change while locked, applied on the next frame boundary.
    ap0 = apply_seen;
    frame(P_PE, P_PE / 2, 0, 2'b01);
    chk("chg_held", screen_mode_out, 2'b00);
    repeat (4) frame(P_CL, -1, 0, 2'b01);
    chk("chg_pulses", apply_seen - ap0, 1);
    chk("chg_mode", screen_mode_out, 2'b01);
    chk("chg_relock", locked, 1);

    // Drift just outside, then just inside tolerance.
    frame(P_CL + 17, -1, 0, 2'b01);
    frame(P_CL + 16, -1, 0, 2'b01);
    chk("drift_unlock", locked, 0);
    frame(P_CL + 16, -1, 0, 2'b01);
    frame(P_CL, -1, 0, 2'b01);
    chk("drift_relock", locked, 1);
    chk("drift_flen", frame_len, P_CL + 16);

    // Signal loss and recovery.
    idle(1200);
    chk("loss_nosig", no_signal, 1);
    frame(P_CL, -1, 0, 2'b01);
    chk("recover_meas", no_signal, 0);

    // Edge landing on the timeout count, then a change cancelled on the edge cycle.
    frame(TMO, -1, 0, 2'b01);
    chk("tmo_edge_sync", no_signal, 0);
    ap0 = apply_seen;
    frame(P_CL, P_CL / 2, 1, 2'b01);
    frame(P_CL, 2, 0, 2'b01);
    chk("cancel_nopulse", apply_seen - ap0, 0);
    chk("cancel_ds80", ds80_out, 0);

    // Reset during MEASURE.
    frame(P_CL / 2, -1, 0, 2'b01);
    reset_pulse();
    chk("midreset_nosig", no_signal, 1);
    chk("midreset_flen", frame_len, 0);
    chk("midreset_mode", screen_mode_out, 2'b00);

    // Randomized traffic.
    for (int it = 0; it < 45; it++) begin
      k    = $urandom_range(0, 9);
      base = exp_period(m_ds, m_sm);
      nds  = ($urandom_range(0, 3) == 0);
      nsm  = 2'($urandom_range(0, 3));
      if (k <= 5) begin
        len = base + $urandom_range(0, 40) - 20;
        chg = ($urandom_range(0, 3) == 0) ? $urandom_range(10, len - 10) : -1;
        frame(len, chg, nds, nsm);
      end else if (k == 6) begin
        frame(base, base / 2, !m_ds, nsm);
        frame(base, 2, m_ds, m_sm);
      end else if (k == 7) begin
        idle($urandom_range(TMO - 5, TMO + 50));
      end else if (k == 8) begin
        reset_pulse();
      end else begin
        len = base + (($urandom_range(0, 1) == 1) ? 1 : -1) * (TOLV + $urandom_range(0, 1));
        frame(len, -1, ds80_in, screen_mode_in);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
